alu_arbiter: RTL

Shares one multi-cycle ALU between `N_REQ` command sources. Requesters are served in round-robin order, with one command in flight at a time. The block issues each granted command to the ALU as a single-cycle start pulse and waits for the ALU's `ready`. It then returns the result, tagged with the requester index, on a valid/ready response port. A watchdog turns a hung ALU operation into an error response, so the arbiter cannot deadlock.

---
 rtl/alu_ctrl_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/alu_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared types for the ALU command arbiter
package alu_ctrl_pkg;

    localparam int DW      = 32;
    localparam int OPW     = 3;
    // Widest requester index (N_REQ up to 8); narrower tops use the low bits.
    localparam int MAX_IDW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DW-1:0]      a;
        logic [DW-1:0]      b;
        logic [OPW-1:0]     op_code;
        logic [MAX_IDW-1:0] id;
    } cmd_t;

    typedef struct packed {
        logic [MAX_IDW-1:0] id;
        logic [DW-1:0]      out;
        logic               carry;
        logic               err;
    } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   idx
);

    always_comb begin
        int           s;
        logic [IDW-1:0] cand;
        logic         found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        s     = 0;
        cand  = '0;
        for (int off = 0; off < N_REQ; off++) begin
            s = int'(ptr) + off;
            if (s >= N_REQ) begin
                s = s - N_REQ;
            end
            cand = IDW'(s);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one multi-cycle ALU with watchdog
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*32-1:0] req_a,
    input  logic [N_REQ*32-1:0] req_b,
    input  logic [N_REQ*3-1:0] req_op,
    output logic               alu_start,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [2:0]         alu_op,
    input  logic               alu_ready,
    input  logic               alu_carry,
    input  logic [31:0]        alu_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_out,
    output logic               rsp_carry,
    output logic               rsp_err
);

    localparam int CW = $clog2(TIMEOUT);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [CW-1:0]    cnt;
    cmd_t             cmd_q;
    rsp_t             rsp_q;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;

    rr_arbiter #(
        .N_REQ(N_REQ),
        .IDW  (IDW)
    ) u_rr (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .en   (state == IDLE),
        .grant(grant),
        .idx  (grant_idx)
    );

    assign req_ready = grant;
    assign alu_start = (state == ISSUE);
    assign alu_a     = cmd_q.a;
    assign alu_b     = cmd_q.b;
    assign alu_op    = cmd_q.op_code;
    assign rsp_valid = (state == RESP);
    assign rsp_id    = rsp_q.id[IDW-1:0];
    assign rsp_out   = rsp_q.out;
    assign rsp_carry = rsp_q.carry;
    assign rsp_err   = rsp_q.err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
            cmd_q  <= '0;
            rsp_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        cmd_q.a       <= req_a[32*int'(grant_idx) +: 32];
                        cmd_q.b       <= req_b[32*int'(grant_idx) +: 32];
                        cmd_q.op_code <= req_op[3*int'(grant_idx) +: 3];
                        cmd_q.id      <= MAX_IDW'(grant_idx);
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A real result wins even on the last watchdog cycle.
                    if (alu_ready) begin
                        rsp_q.id    <= cmd_q.id;
                        rsp_q.out   <= alu_out;
                        rsp_q.carry <= alu_carry;
                        rsp_q.err   <= 1'b0;
                        state       <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_q.id    <= cmd_q.id;
                        rsp_q.out   <= '0;
                        rsp_q.carry <= 1'b0;
                        rsp_q.err   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        if (rsp_q.id == MAX_IDW'(N_REQ - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= IDW'(rsp_q.id + MAX_IDW'(1));
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
